dm_access_arbiter: RTL and testbench
====================================

# dm_access_arbiter

Sequencer and arbiter in front of the data memory: shares the single-ported DM between the CPU memory stage (port 0) and a loader/debug master (port 1). Each access runs a fixed three-state sequence: latch request, perform DM access, return acknowledge. The block converts size and address into DM byte enables and extends read data, and raises a stall to the pipeline while the CPU's access is outstanding.

## Interface
- `CPU_PRIORITY`, 0: 0 = round-robin between ports; 1 = port 0 always wins ties.
- `ERR_ON_MISALIGN`, 1: 1 = misaligned access is acked with `err`, with no write; 0 = low address bits are ignored (forced-aligned).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`/`req1`  in  1  access request; held with its fields until the matching ack.
- `we0`/`we1`  in  1  1 = store, 0 = load.
- `addr0`/`addr1`  in  32  byte address.
- `wdata0`/`wdata1`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `size0`/`size1`  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `sext0`/`sext1`  in  1  sign-extend load data.
- `pc0`  in  32  CPU PC, forwarded to the DM for store logging.
- `ack0`/`ack1`  out  1  one-cycle completion pulse.
- `rdata0`/`rdata1`  out  32  extended load data, valid while ack is high.
- `err`  out  1  misalignment flag, qualified by the ack of the same cycle.
- `cpu_stall`  out  1  `req0 & ~ack0`.
- `dm_address`  out  32  DM address.
- `dm_data_in`  out  32  DM write data.
- `dm_write`  out  1  DM write enable.
- `BE`  out  4  DM byte enables.
- `pc_now`  out  32  PC for DM logging.
- `dm_data_out`  in  32  combinational DM read word.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the winner, latch its fields into the command register and `owner`, then go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high, round-robin: the port ≠ `last` wins.
  - Both high, `CPU_PRIORITY`=1: port 0 wins.
  - `last` is updated to the winner on every grant.
- ACCESS:
  - Drive DM from the command register. `dm_write = we & ~misaligned`.
  - The DM commits the write on this cycle's rising edge.
  - Sample `dm_data_out` into the read register with lane extraction, then go to RESP.
- RESP: `ack[owner]=1` for exactly one cycle, then go to IDLE. A request still high in IDLE is treated as a new request.
- BE mapping:
  - word: 1111.
  - half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - byte: 0001 << addr[1:0].
  - `dm_data_in` = wdata unshifted (the DM takes its data from low lanes).
  - `dm_address` = {addr[31:2], 2'b00}.
- Read extraction: select lane byte/half by addr[1:0]/addr[1], then zero- or sign-extend per `sext`. Word loads pass through unchanged.
- Misaligned means word with addr[1:0]≠0, or half with addr[0]=1:
  - `ERR_ON_MISALIGN`=1: no write, `rdata`=0, `err`=1 in RESP.
  - `ERR_ON_MISALIGN`=0: low bits are forced aligned and the access proceeds.
- `pc_now` = `pc0` when owner = 0, else 0.
- Outside ACCESS: `dm_write`=0 and `BE`=0000. `dm_address` holds its last value.

## Timing
- Reset values: state IDLE, `last`=1 (port 0 wins first), `ack0`/`ack1`/`err`=0, `rdata0`/`rdata1`=0, `dm_write`=0, `BE`=0, `dm_address`/`dm_data_in`/`pc_now`=0.
- Latency: req sampled in IDLE at cycle N, DM access at N+1, ack at N+2.
- Throughput: one access per 3 cycles. A continuously held req is re-granted at N+3.
- Reset asserted mid-ACCESS: `dm_write` drops immediately (asynchronous), so no write occurs on the following edge. No ack is issued. The requester must re-issue after reset.
- A req dropped before its ack is illegal; the latched request still completes.
- The req of the losing port stays pending. `cpu_stall` stays high through a port-1 access.

## Structure
- Shared package `dm_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, BE constants.
- Sub-module `dm_lane_align` (combinational): size + addr[1:0] + wdata/rdata + sext → BE, misaligned, extended read data.
- `dm_lane_align` is reused by the pipeline's forwarding check.

## Test plan
- Store word, port 0: addr=0x10, wdata=0xDEADBEEF. Required: at N+1, `dm_write`=1, `BE`=1111, `dm_address`=0x10; `ack0` at N+2. A following load of 0x10 returns 0xDEADBEEF.
- Store byte, port 1: addr=0x13, wdata=0xAB. Required: `BE`=1000. A load-byte of 0x13 with sext=1 returns 0xFFFFFFAB; with sext=0 it returns 0x000000AB.
- Both ports request every cycle, `CPU_PRIORITY`=0. Required: grants alternate 0,1,0,1, with acks 3 cycles apart; `cpu_stall` is high except in `ack0` cycles.
- `CPU_PRIORITY`=1, both ports request. Required: port 0 is granted each round and port 1 waits until `req0` drops.
- Misaligned half store to 0x21. Required: `dm_write` stays 0, `ack0` with `err`=1, memory unchanged.
- `reset` pulsed low during ACCESS of a store. Required: `dm_write`=0 at the next edge, no ack, memory unchanged, FSM in IDLE with `last`=1.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access arbiter: size codes, FSM states,
// byte-enable constants and the latched command record.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] pc;
    } dm_cmd_t;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: byte enables, misalignment flag and extended load data
// from access size and the two low address bits.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic        sext,
    output logic [3:0]  be,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Halves ignore addr[0] and words ignore addr[1:0], so a misaligned access
    // naturally lands on the forced-aligned lanes.
    always_comb begin
        be         = BE_WORD;
        misaligned = 1'b0;
        rdata_ext  = rword;
        case (size)
            SZ_BYTE: begin
                be        = BE_BYTE0 << addr_lo;
                rdata_ext = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                misaligned = addr_lo[0];
                rdata_ext  = {{16{sext & half_sel[15]}}, half_sel};
            end
            default: begin
                be         = BE_WORD;
                misaligned = |addr_lo;
                rdata_ext  = rword;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Two-port sequencer in front of the single-ported data memory: arbitrates between
// the CPU (port 0) and a loader/debug master (port 1), one access every three cycles.
module dm_access_arbiter
    import dm_pkg::*;
#(
    parameter int CPU_PRIORITY    = 0,
    parameter int ERR_ON_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [1:0]  size0,
    input  logic        sext0,
    input  logic [31:0] pc0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [1:0]  size1,
    input  logic        sext1,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err,
    output logic        cpu_stall,
    output logic [31:0] dm_address,
    output logic [31:0] dm_data_in,
    output logic        dm_write,
    output logic [3:0]  BE,
    output logic [31:0] pc_now,
    input  logic [31:0] dm_data_out
);

    localparam bit ERR_EN  = (ERR_ON_MISALIGN != 0);
    localparam bit PRIO_EN = (CPU_PRIORITY != 0);

    dm_state_e   state_reg, state_next;
    dm_cmd_t     cmd_reg;
    logic        owner_reg;
    logic        last_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    logic        any_req;
    logic        grant1;
    logic        resp_active;
    logic        bad_access;
    logic [3:0]  lane_be;
    logic        lane_mis;
    logic [31:0] lane_rdata;
    logic [1:0]  ack_vec;
    logic [31:0] rdata_vec [2];

    assign any_req = req0 | req1;
    // Round-robin: on a tie the port that was not granted last time wins.
    assign grant1  = req1 & (~req0 | (~PRIO_EN & ~last_reg));

    dm_lane_align u_align (
        .size       (cmd_reg.size),
        .addr_lo    (cmd_reg.addr[1:0]),
        .rword      (dm_data_out),
        .sext       (cmd_reg.sext),
        .be         (lane_be),
        .misaligned (lane_mis),
        .rdata_ext  (lane_rdata)
    );

    assign bad_access = ERR_EN & lane_mis;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (any_req) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // dm_write decodes straight from state so an asynchronous reset kills it at once.
    always_comb begin
        dm_write    = 1'b0;
        BE          = BE_NONE;
        resp_active = 1'b0;
        case (state_reg)
            ST_ACCESS: begin
                dm_write = cmd_reg.we & ~bad_access;
                BE       = lane_be;
            end
            ST_RESP:   resp_active = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_reg   <= '0;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && any_req) begin
                owner_reg <= grant1;
                last_reg  <= grant1;
                if (grant1) begin
                    cmd_reg <= '{we: we1, addr: addr1, wdata: wdata1,
                                 size: size1, sext: sext1, pc: 32'h0};
                end else begin
                    cmd_reg <= '{we: we0, addr: addr0, wdata: wdata0,
                                 size: size0, sext: sext0, pc: pc0};
                end
            end
            if (state_reg == ST_ACCESS) begin
                rdata_reg <= bad_access ? 32'h0 : lane_rdata;
                err_reg   <= bad_access;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign ack_vec[gi]   = resp_active && (owner_reg == 1'(gi));
        assign rdata_vec[gi] = ack_vec[gi] ? rdata_reg : 32'h0;
    end

    assign ack0       = ack_vec[0];
    assign ack1       = ack_vec[1];
    assign rdata0     = rdata_vec[0];
    assign rdata1     = rdata_vec[1];
    assign err        = resp_active & err_reg;
    assign cpu_stall  = req0 & ~ack0;
    assign dm_address = {cmd_reg.addr[31:2], 2'b00};
    assign dm_data_in = cmd_reg.wdata;
    assign pc_now     = cmd_reg.pc;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench: a round-robin/error instance and a priority/forced-align instance
// share stimulus, each with its own behavioural data memory.
module tb_dm_access_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, sext0, req1, we1, sext1;
    logic [31:0] addr0, wdata0, pc0, addr1, wdata1;
    logic [1:0]  size0, size1;

    logic        ack0, ack1, err, cpu_stall, dm_write;
    logic [31:0] rdata0, rdata1, dm_address, dm_data_in, pc_now, dm_data_out;
    logic [3:0]  be;

    logic        ack0_p, ack1_p, err_p, cpu_stall_p, dm_write_p;
    logic [31:0] rdata0_p, rdata1_p, dm_address_p, dm_data_in_p, pc_now_p, dm_data_out_p;
    logic [3:0]  be_p;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    int checks;
    int failures;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        logic        chk_be;
        logic [3:0]  be;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    dm_access_arbiter #(.CPU_PRIORITY(0), .ERR_ON_MISALIGN(1)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .size0(size0),
        .sext0(sext0), .pc0(pc0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .size1(size1),
        .sext1(sext1),
        .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1), .err(err),
        .cpu_stall(cpu_stall), .dm_address(dm_address), .dm_data_in(dm_data_in),
        .dm_write(dm_write), .BE(be), .pc_now(pc_now), .dm_data_out(dm_data_out)
    );

    dm_access_arbiter #(.CPU_PRIORITY(1), .ERR_ON_MISALIGN(0)) u_pri (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .size0(size0),
        .sext0(sext0), .pc0(pc0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .size1(size1),
        .sext1(sext1),
        .ack0(ack0_p), .rdata0(rdata0_p), .ack1(ack1_p), .rdata1(rdata1_p), .err(err_p),
        .cpu_stall(cpu_stall_p), .dm_address(dm_address_p), .dm_data_in(dm_data_in_p),
        .dm_write(dm_write_p), .BE(be_p), .pc_now(pc_now_p), .dm_data_out(dm_data_out_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DM: sub-word store data arrives in the low lanes and is placed
    // starting at the lowest enabled byte.
    function automatic logic [31:0] dm_merge(input logic [31:0] old, input logic [31:0] din,
                                             input logic [3:0] ben);
        logic [31:0] res;
        logic [31:0] sh;
        int low;
        low = 0;
        for (int i = 3; i >= 0; i--) if (ben[i]) low = i;
        sh  = din << (8 * low);
        res = old;
        for (int i = 0; i < 4; i++) if (ben[i]) res[8*i +: 8] = sh[8*i +: 8];
        return res;
    endfunction

    assign dm_data_out   = mem_a[dm_address[7:2]];
    assign dm_data_out_p = mem_b[dm_address_p[7:2]];

    always @(posedge clk) begin
        if (dm_write)   mem_a[dm_address[7:2]]   <= dm_merge(mem_a[dm_address[7:2]], dm_data_in, be);
        if (dm_write_p) mem_b[dm_address_p[7:2]] <= dm_merge(mem_b[dm_address_p[7:2]], dm_data_in_p, be_p);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; size0 = 0; sext0 = 0; pc0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; size1 = 0; sext1 = 0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [31:0] pcv;
        logic [31:0] rd;
        v   = vecs[idx];
        pcv = 32'h1000 + 32'(idx * 4);
        pc0 = pcv;
        if (v.port == 1'b0) begin
            req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; size0 = v.size; sext0 = v.sext;
        end else begin
            req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; size1 = v.size; sext1 = v.sext;
        end
        @(negedge clk);
        chk("access_dm_write", {31'h0, dm_write}, {31'h0, v.we & ~v.err});
        if (v.chk_be) chk("access_be", {28'h0, be}, {28'h0, v.be});
        chk("access_addr", dm_address, {v.addr[31:2], 2'b00});
        chk("access_pc_now", pc_now, v.port ? 32'h0 : pcv);
        chk("access_no_ack", {30'h0, ack1, ack0}, 32'h0);
        @(negedge clk);
        chk("resp_ack0", {31'h0, ack0}, {31'h0, ~v.port});
        chk("resp_ack1", {31'h0, ack1}, {31'h0, v.port});
        chk("resp_err", {31'h0, err}, {31'h0, v.err});
        rd = v.port ? rdata1 : rdata0;
        if (v.chk_rd) chk("resp_rdata", rd, v.rdata);
        $display("vec %0d port=%0d we=%0d size=%0d addr=%08h rdata=%08h err=%0d",
                 idx, v.port, v.we, v.size, v.addr, rd, err);
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        logic e0, e1;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end

        //          port we  addr      wdata          size  sext chkbe be    err  chkrd rdata
        vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h13, 32'hAB,       2'd0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h13, 32'h0,        2'd0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 32'hFFFFFFAB};
        vecs[4]  = '{1'b0, 1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 32'h000000AB};
        vecs[5]  = '{1'b0, 1'b1, 32'h22, 32'h12348001, 2'd1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h22, 32'h0,        2'd1, 1'b1, 1'b1, 4'hC, 1'b0, 1'b1, 32'hFFFF8001};
        vecs[7]  = '{1'b0, 1'b0, 32'h22, 32'h0,        2'd1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 32'h00008001};
        vecs[8]  = '{1'b0, 1'b0, 32'h20, 32'h0,        2'd1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h11, 32'h0,        2'd0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 32'hFFFFFFBE};
        vecs[10] = '{1'b0, 1'b1, 32'h21, 32'h5555,     2'd1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 32'h80010000};
        vecs[12] = '{1'b1, 1'b0, 32'h12, 32'h0,        2'd2, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h10, 32'h0,        2'd2, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 32'hABADBEEF};
        vecs[14] = '{1'b1, 1'b1, 32'h30, 32'h0BADF00D, 2'd3, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 1'b0, 32'h30, 32'h0,        2'd3, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 32'h0BADF00D};

        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {24'h0, be, dm_write, err, ack1, ack0}, 32'h0);
        chk("reset_rdata", rdata0 | rdata1, 32'h0);
        chk("reset_bus", dm_address | dm_data_in | pc_now, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        chk("mem_misalign_err_untouched", mem_a[8], 32'h80010000);
        chk("mem_misalign_forced_aligned", mem_b[8], 32'h80015555);

        // Reset pulse in the middle of a store's ACCESS cycle.
        req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'h12345678; size0 = 2'd2; pc0 = 32'h2000;
        @(negedge clk);
        chk("rst_mid_access_write", {31'h0, dm_write}, 32'h1);
        #2 reset = 1'b0;
        #1 chk("rst_drops_write", {31'h0, dm_write}, 32'h0);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        $display("reset pulse during store to 00000040");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_ack", {30'h0, ack1, ack0}, 32'h0);
        end
        chk("rst_mem_unchanged", mem_a[16], 32'h0);

        // Both ports held: round-robin alternates from port 0, priority keeps port 0.
        req0 = 1; addr0 = 32'h10; size0 = 2'd2;
        req1 = 1; addr1 = 32'h30; size1 = 2'd2;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            e0 = (k == 2) || (k == 8);
            e1 = (k == 5) || (k == 11);
            chk("rr_ack_stall", {29'h0, ack0, ack1, cpu_stall}, {29'h0, e0, e1, ~e0});
            e0 = (k == 2) || (k == 5) || (k == 8) || (k == 11);
            chk("pri_ack_stall", {29'h0, ack0_p, ack1_p, cpu_stall_p}, {29'h0, e0, 1'b0, ~e0});
            if (ack0 | ack1 | ack0_p | ack1_p)
                $display("both-req cycle %0d rr_ack=%0d%0d pri_ack=%0d%0d",
                         k, ack1, ack0, ack1_p, ack0_p);
        end
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_port1_after_drop", {30'h0, ack1, ack0}, 32'h2);
        chk("pri_port1_after_drop", {30'h0, ack1_p, ack0_p}, 32'h2);
        chk("pri_port1_rdata", rdata1_p, 32'h0BADF00D);
        $display("port 1 served after req0 drop rdata=%08h", rdata1_p);
        idle_inputs();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
